// File: rtl/viterbi_pkg.sv
// Shared definitions for the rate-1/2 convolutional encoder and its Viterbi decoder:
// default code parameters, encoder FSM states and the parity helper.
package viterbi_pkg;

    localparam int               ENC_K  = 3;
    localparam logic [ENC_K-1:0] ENC_G0 = 3'b111;
    localparam logic [ENC_K-1:0] ENC_G1 = 3'b101;

    typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_t;

    function automatic logic parity(input logic [31:0] w, input logic [31:0] g);
        return ^(w & g);
    endfunction

endpackage

// File: rtl/conv_encoder_framed_if.sv
// Bit-in / symbol-out bus of the framed convolutional encoder.
// The source of information bits uses master; the encoder uses slave.
interface conv_encoder_framed_if;

    logic        enable_i;
    logic        d_in;
    logic        ready_o;
    logic        valid_o;
    logic [1:0]  d_out;
    logic        sof_o;
    logic        eof_o;
    logic [15:0] frame_ct_o;

    modport master (
        output enable_i, d_in,
        input  ready_o, valid_o, d_out, sof_o, eof_o, frame_ct_o
    );

    modport slave (
        input  enable_i, d_in,
        output ready_o, valid_o, d_out, sof_o, eof_o, frame_ct_o
    );

endinterface

// File: rtl/conv_enc_core.sv
// Shift register plus two generator parity taps; emits one registered 2-bit symbol per shift.
// sr[0] holds the previous input bit, sr[K-2] the oldest.
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter int           K  = ENC_K,
    parameter logic [K-1:0] G0 = ENC_G0,
    parameter logic [K-1:0] G1 = ENC_G1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_en,
    input  logic       b,
    input  logic       clr,
    output logic [1:0] sym
);

    logic [K-2:0] sr;
    logic [K-2:0] sr_next;
    logic [K-1:0] w;

    // Window runs newest to oldest below b, so a generator MSB taps b and its LSB
    // the oldest bit: the usual octal 7/5 convention the decoder expects.
    always_comb begin
        w[K-1]     = b;
        sr_next[0] = b;
        for (int i = 0; i < K-1; i++) begin
            w[K-2-i] = sr[i];
        end
        for (int i = 1; i < K-1; i++) begin
            sr_next[i] = sr[i-1];
        end
    end

    // NOTE: non-blocking updates so sym is computed from the window as it was before this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr  <= '0;
            sym <= 2'b00;
        end else if (shift_en) begin
            sym <= {parity(32'(w), 32'(G0)), parity(32'(w), 32'(G1))};
            sr  <= clr ? '0 : sr_next;
        end
    end

endmodule

// File: rtl/conv_encoder_framed.sv
// Framed rate-1/2 convolutional encoder: frame FSM, bit/tail counters and sof/eof flags
// around conv_enc_core, appending K-1 zero tail bits so the trellis terminates in state 0.
module conv_encoder_framed
    import viterbi_pkg::*;
#(
    parameter int           K         = ENC_K,
    parameter logic [K-1:0] G0        = ENC_G0,
    parameter logic [K-1:0] G1        = ENC_G1,
    parameter int           FRAME_LEN = 256,
    parameter bit           TAIL_EN   = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    conv_encoder_framed_if.slave bus
);

    localparam int BCW = $clog2(FRAME_LEN + 1);
    localparam int TCW = (K > 2) ? $clog2(K - 1) : 1;

    enc_state_t     state, state_next;
    logic [BCW-1:0] bit_ct, bit_ct_next;
    logic [TCW-1:0] tail_ct, tail_ct_next;
    logic [15:0]    frame_ct;
    logic           valid, sof, eof;
    logic           accept, last_bit, last_tail;
    logic           shift_en, core_b, clr, frame_done, sof_next;
    logic [1:0]     sym;

    assign accept    = bus.enable_i && (state != TAIL);
    assign last_bit  = accept && (bit_ct == BCW'(FRAME_LEN - 1));
    assign last_tail = (state == TAIL) && (tail_ct == TCW'(K - 2));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        bit_ct_next  = bit_ct;
        tail_ct_next = tail_ct;
        shift_en     = 1'b0;
        core_b       = bus.d_in;
        clr          = 1'b0;
        frame_done   = 1'b0;
        sof_next     = 1'b0;
        unique case (state)
            IDLE, DATA: begin
                if (accept) begin
                    shift_en    = 1'b1;
                    sof_next    = (state == IDLE);
                    bit_ct_next = bit_ct + 1'b1;
                    state_next  = DATA;
                    if (last_bit) begin
                        if (TAIL_EN) begin
                            state_next   = TAIL;
                            tail_ct_next = '0;
                        end else begin
                            // Without a tail the next frame must start from the all-zero state.
                            clr         = 1'b1;
                            frame_done  = 1'b1;
                            bit_ct_next = '0;
                            state_next  = IDLE;
                        end
                    end
                end
            end
            TAIL: begin
                shift_en     = 1'b1;
                core_b       = 1'b0;
                tail_ct_next = tail_ct + 1'b1;
                if (last_tail) begin
                    frame_done  = 1'b1;
                    bit_ct_next = '0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_ct   <= '0;
            tail_ct  <= '0;
            valid    <= 1'b0;
            sof      <= 1'b0;
            eof      <= 1'b0;
            frame_ct <= '0;
        end else begin
            state   <= state_next;
            bit_ct  <= bit_ct_next;
            tail_ct <= tail_ct_next;
            valid   <= shift_en;
            sof     <= sof_next;
            eof     <= frame_done;
            if (frame_done) begin
                frame_ct <= frame_ct + 16'd1;
            end
        end
    end

    conv_enc_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .b        (core_b),
        .clr      (clr),
        .sym      (sym)
    );

    assign bus.ready_o    = (state != TAIL);
    assign bus.valid_o    = valid;
    assign bus.d_out      = sym;
    assign bus.sof_o      = sof;
    assign bus.eof_o      = eof;
    assign bus.frame_ct_o = frame_ct;

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Self-checking bench for conv_encoder_framed: K=3, G 7/5, FRAME_LEN=4 with tail,
// plus a FRAME_LEN=1 instance without tail; random traffic checked against a behavioural model.
module tb_conv_encoder_framed;

    localparam logic [2:0] G0_REF = 3'b111;
    localparam logic [2:0] G1_REF = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   frames_exp  = 0;
    int   frames1_exp = 0;
    logic [1:0] last_sym  = 2'b00;
    logic [1:0] last_sym1 = 2'b00;

    conv_encoder_framed_if bus ();
    conv_encoder_framed_if bus1 ();

    conv_encoder_framed #(.FRAME_LEN(4), .TAIL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    conv_encoder_framed #(.FRAME_LEN(1), .TAIL_EN(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Behavioural encoder: symbol n of a 4-bit frame followed by two zero tail bits.
    // Each output bit is the XOR of the stream bits x[n-j] selected by generator bit 2-j.
    function automatic logic [1:0] model_sym(input logic [3:0] bits, input int n);
        logic [1:0] s  = 2'b00;
        logic [2:0] g0 = G0_REF;
        logic [2:0] g1 = G1_REF;
        logic       x;
        for (int j = 0; j < 3; j++) begin
            x = 1'b0;
            if (n - j >= 0 && n - j < 4) x = bits[n-j];
            s[1] = s[1] ^ (x & g0[2-j]);
            s[0] = s[0] ^ (x & g1[2-j]);
        end
        return s;
    endfunction

    // Maximum-likelihood decode by exhaustive search over all 16 frames (min Hamming distance).
    function automatic logic [3:0] ml_decode(input logic [1:0] obs[$]);
        int         best_d = 1000;
        logic [3:0] best   = 4'h0;
        int         d;
        logic [3:0] cand;
        logic [1:0] e;
        for (int c = 0; c < 16; c++) begin
            cand = 4'(c);
            d = 0;
            for (int n = 0; n < 6; n++) begin
                e = model_sym(cand, n);
                if (n < obs.size()) d += int'(e[1] ^ obs[n][1]) + int'(e[0] ^ obs[n][0]);
                else d += 2;
            end
            if (d < best_d) begin
                best_d = d;
                best   = cand;
            end
        end
        return best;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        bus.enable_i  = 1'b0;
        bus.d_in      = 1'b0;
        bus1.enable_i = 1'b0;
        bus1.d_in     = 1'b0;
        rst = 1'b0;
        #12;
        got = {bus.ready_o, bus.valid_o, bus.sof_o, bus.eof_o, bus.d_out};
        total++;
        if (got !== 6'b100000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b", got, 6'b100000);
        end
        total++;
        if (bus.frame_ct_o !== 16'd0) begin
            bad++;
            $display("FAIL reset_frame_ct got=%0d want=0", bus.frame_ct_o);
        end
        got = {bus1.ready_o, bus1.valid_o, bus1.sof_o, bus1.eof_o, bus1.d_out};
        total++;
        if (got !== 6'b100000 || bus1.frame_ct_o !== 16'd0) begin
            bad++;
            $display("FAIL reset_outputs_nt got=%b/%0d want=%b/0", got, bus1.frame_ct_o, 6'b100000);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
    endtask

    // Known vector 1,1,0,1 -> 11,01,01,00 then tail 10,11.
    task automatic test_basic();
        logic [1:0] exp_sym [6] = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11};
        logic       din     [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [5:0] got, want;
        for (int c = 0; c < 6; c++) begin
            bus.enable_i = (c < 4);
            bus.d_in     = (c < 4) ? din[c] : 1'b0;
            tick();
            got  = {bus.ready_o, bus.valid_o, bus.sof_o, bus.eof_o, bus.d_out};
            want = {!(c == 3 || c == 4), 1'b1, c == 0, c == 5, exp_sym[c]};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL basic_sym%0d got=%b want=%b", c, got, want);
            end
        end
        bus.enable_i = 1'b0;
        last_sym = exp_sym[5];
        frames_exp++;
        total++;
        if (bus.frame_ct_o !== 16'(frames_exp)) begin
            bad++;
            $display("FAIL basic_frame_ct got=%0d want=%0d", bus.frame_ct_o, frames_exp);
        end
    endtask

    // Impulse 1,0,0,0 -> 11,10,11,00,00,00 with ready low for exactly two cycles.
    task automatic test_impulse();
        logic [1:0] exp_sym [6] = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
        logic [5:0] got, want;
        for (int c = 0; c < 6; c++) begin
            bus.enable_i = (c < 4);
            bus.d_in     = (c == 0);
            tick();
            got  = {bus.ready_o, bus.valid_o, bus.sof_o, bus.eof_o, bus.d_out};
            want = {!(c == 3 || c == 4), 1'b1, c == 0, c == 5, exp_sym[c]};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL impulse_sym%0d got=%b want=%b", c, got, want);
            end
        end
        bus.enable_i = 1'b0;
        last_sym = exp_sym[5];
        frames_exp++;
    endtask

    // Random frame with enable toggling 1,0,1,0; gaps hold d_out and drop valid.
    task automatic test_gaps();
        logic [3:0] bits = 4'($urandom);
        logic [5:0] got, want;
        int         k;
        for (int c = 0; c < 9; c++) begin
            if (c < 7) begin
                bus.enable_i = (c % 2 == 0);
                bus.d_in     = (c % 2 == 0) ? bits[c/2] : 1'($urandom);
            end else begin
                bus.enable_i = 1'($urandom);
                bus.d_in     = 1'($urandom);
            end
            tick();
            if (c < 7 && c % 2 == 1) begin
                want = {1'b1, 1'b0, 1'b0, 1'b0, last_sym};
            end else begin
                k    = (c < 7) ? c / 2 : c - 3;
                want = {!(k == 3 || k == 4), 1'b1, k == 0, k == 5, model_sym(bits, k)};
                last_sym = model_sym(bits, k);
            end
            got = {bus.ready_o, bus.valid_o, bus.sof_o, bus.eof_o, bus.d_out};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL gaps_cycle%0d bits=%b got=%b want=%b", c, bits, got, want);
            end
        end
        bus.enable_i = 1'b0;
        frames_exp++;
    endtask

    // enable held high with d_in=1 through the tail; next frame starts as ready returns.
    task automatic test_back_to_back();
        logic [3:0] bits [2];
        logic [5:0] got, want;
        int         k, f;
        bits[0] = 4'($urandom);
        bits[1] = 4'($urandom);
        for (int c = 0; c < 12; c++) begin
            k = c % 6;
            f = c / 6;
            bus.enable_i = 1'b1;
            bus.d_in     = (k < 4) ? bits[f][k] : 1'b1;
            tick();
            want = {!(k == 3 || k == 4), 1'b1, k == 0, k == 5, model_sym(bits[f], k)};
            got  = {bus.ready_o, bus.valid_o, bus.sof_o, bus.eof_o, bus.d_out};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL b2b_cycle%0d bits=%b got=%b want=%b", c, bits[f], got, want);
            end
        end
        bus.enable_i = 1'b0;
        last_sym = model_sym(bits[1], 5);
        frames_exp += 2;
        total++;
        if (bus.frame_ct_o !== 16'(frames_exp)) begin
            bad++;
            $display("FAIL b2b_frame_ct got=%0d want=%0d", bus.frame_ct_o, frames_exp);
        end
    endtask

    // Reset after two data bits aborts the frame; the next frame encodes from scratch.
    task automatic test_reset_mid();
        logic [3:0] bits = 4'($urandom);
        logic [5:0] got, want;
        for (int c = 0; c < 2; c++) begin
            bus.enable_i = 1'b1;
            bus.d_in     = 1'($urandom);
            tick();
        end
        bus.enable_i = 1'b0;
        #2 rst = 1'b0;
        #2;
        got = {bus.ready_o, bus.valid_o, bus.sof_o, bus.eof_o, bus.d_out};
        total++;
        if (got !== 6'b100000 || bus.frame_ct_o !== 16'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%b/%0d want=%b/0", got, bus.frame_ct_o, 6'b100000);
        end
        #2 rst = 1'b1;
        frames_exp  = 0;
        frames1_exp = 0;
        last_sym1   = 2'b00;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            bus.enable_i = (c < 4);
            bus.d_in     = (c < 4) ? bits[c] : 1'b0;
            tick();
            want = {!(c == 3 || c == 4), 1'b1, c == 0, c == 5, model_sym(bits, c)};
            got  = {bus.ready_o, bus.valid_o, bus.sof_o, bus.eof_o, bus.d_out};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL midreset_sym%0d bits=%b got=%b want=%b", c, bits, got, want);
            end
        end
        bus.enable_i = 1'b0;
        last_sym = model_sym(bits, 5);
        frames_exp++;
        total++;
        if (bus.frame_ct_o !== 16'(frames_exp)) begin
            bad++;
            $display("FAIL midreset_frame_ct got=%0d want=%0d", bus.frame_ct_o, frames_exp);
        end
    endtask

    // FRAME_LEN=1, no tail: every bit is its own frame and sees a cleared register.
    task automatic test_no_tail();
        logic [5:0] got, want;
        logic       en, d;
        for (int c = 0; c < 10; c++) begin
            en = (c < 2) ? 1'b1 : 1'($urandom);
            d  = (c < 2) ? 1'b1 : 1'($urandom);
            bus1.enable_i = en;
            bus1.d_in     = d;
            tick();
            if (en) begin
                want = {1'b1, 1'b1, 1'b1, 1'b1, d, d};
                last_sym1 = {d, d};
                frames1_exp++;
            end else begin
                want = {1'b1, 1'b0, 1'b0, 1'b0, last_sym1};
            end
            got = {bus1.ready_o, bus1.valid_o, bus1.sof_o, bus1.eof_o, bus1.d_out};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL notail_cycle%0d got=%b want=%b", c, got, want);
            end
        end
        bus1.enable_i = 1'b0;
        total++;
        if (bus1.frame_ct_o !== 16'(frames1_exp)) begin
            bad++;
            $display("FAIL notail_frame_ct got=%0d want=%0d", bus1.frame_ct_o, frames1_exp);
        end
    endtask

    // 64 random frames with random gaps, decoded by ML search over a clean channel.
    task automatic test_loopback();
        logic [3:0] bits;
        logic [1:0] obs[$];
        logic [3:0] dec;
        int         bi, cyc;
        logic       acc;
        int         frame_errs = 0;
        for (int f = 0; f < 64; f++) begin
            bits = 4'($urandom);
            bi   = 0;
            cyc  = 0;
            obs.delete();
            while (obs.size() < 6 && cyc < 40) begin
                bus.enable_i = (bi < 4) && ($urandom_range(0, 3) != 0);
                bus.d_in     = (bi < 4) ? bits[bi[1:0]] : 1'($urandom);
                acc = bus.enable_i && bus.ready_o;
                tick();
                if (acc) bi++;
                if (bus.valid_o) obs.push_back(bus.d_out);
                cyc++;
            end
            bus.enable_i = 1'b0;
            dec = ml_decode(obs);
            total++;
            if (obs.size() != 6 || dec !== bits) begin
                bad++;
                frame_errs++;
                $display("FAIL loopback_frame%0d syms=%0d decoded=%b want=%b", f, obs.size(), dec, bits);
            end
            frames_exp++;
        end
        total++;
        if (bus.frame_ct_o !== 16'(frames_exp)) begin
            bad++;
            $display("FAIL loopback_frame_ct got=%0d want=%0d", bus.frame_ct_o, frames_exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_impulse();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_no_tail();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
